// File: rtl/fdiv_if.sv
// Start/valid bus for the iterative floating-point divider (fdiv_iter).
// Handshake: the master pulses ready for one cycle with x1/x2 stable; the slave raises busy
// from the next cycle and later pulses valid for one cycle, with y_reg/ovf_reg stable until
// the next valid. A ready while busy aborts the running divide and restarts it.
interface fdiv_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         ready;
  logic [W-1:0] x1;
  logic [W-1:0] x2;
  logic [W-1:0] y_reg;
  logic         ovf_reg;
  logic         valid;
  logic         busy;

  modport master (output ready, x1, x2, input y_reg, ovf_reg, valid, busy);
  modport slave  (input ready, x1, x2, output y_reg, ovf_reg, valid, busy);
endinterface

// File: rtl/fdiv_iter.sv
// Iterative radix-2 restoring floating-point divider, fixed latency of MAN_W+4 edges.
// Define FDIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fdiv_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic       clk,
  input  logic       rst,
  fdiv_if.slave      bus,
  output logic [1:0] o_dbg_state
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int EW    = EXP_W + 2;
  localparam int RW    = MAN_W + 2;
  localparam int QW    = MAN_W + 2;
  localparam int NITER = MAN_W + 2;
  localparam int CW    = $clog2(NITER);
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PREP  = 2'd1;
  localparam logic [1:0] ITER  = 2'd2;
  localparam logic [1:0] ROUND = 2'd3;

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_INF  = 2'd1;
  localparam logic [1:0] CLS_ZERO = 2'd2;

  logic [1:0]           r_state;
  logic [W-1:0]         r_x1;
  logic [W-1:0]         r_x2;
  logic [RW-1:0]        r_rem;
  logic [MAN_W:0]       r_mb;
  logic [QW-1:0]        r_q;
  logic signed [EW-1:0] r_e;
  logic                 r_sign;
  logic [1:0]           r_cls;
  logic [CW-1:0]        r_cnt;
  logic [W-1:0]         r_y;
  logic                 r_ovf;
  logic                 r_valid;

  // Operand unpack (PREP): denormals are flushed by treating exp==0 as zero.
  logic [EXP_W-1:0]     w_e1, w_e2;
  logic [MAN_W:0]       w_ma, w_mb;
  logic                 w_z1, w_z2, w_i1, w_i2, w_adj;
  logic [RW-1:0]        w_rem0;
  logic signed [EW-1:0] w_e0;
  logic [1:0]           w_cls;

  assign w_e1   = r_x1[W-2:MAN_W];
  assign w_e2   = r_x2[W-2:MAN_W];
  assign w_ma   = {1'b1, r_x1[MAN_W-1:0]};
  assign w_mb   = {1'b1, r_x2[MAN_W-1:0]};
  assign w_z1   = (w_e1 == '0);
  assign w_z2   = (w_e2 == '0);
  assign w_i1   = &w_e1;
  assign w_i2   = &w_e2;
  assign w_adj  = (w_ma < w_mb);
  assign w_rem0 = w_adj ? {w_ma, 1'b0} : {1'b0, w_ma};
  assign w_e0   = EW'(w_e1) - EW'(w_e2) + EW'(BIAS) - EW'(w_adj);
  assign w_cls  = (w_z2 || w_i1) ? CLS_INF : ((w_z1 || w_i2) ? CLS_ZERO : CLS_NORM);

  // One restoring step per ITER cycle.
  logic          w_ge;
  logic [RW-1:0] w_sub;

  assign w_ge  = (r_rem >= {1'b0, r_mb});
  assign w_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  // Round and pack (ROUND). r_q holds MAN_W+1 mantissa bits followed by the guard bit.
  logic [MAN_W:0]       w_mant;
  logic                 w_inc;
  logic [MAN_W+1:0]     w_mant_r;
  logic                 w_carry;
  logic signed [EW-1:0] w_ef;
  logic [W-1:0]         w_y;
  logic                 w_ovf;
  logic                 w_unused;

  assign w_mant = r_q[QW-1:1];
`ifdef FDIV_RNE_EN
  assign w_inc    = r_q[0] & ((|r_rem) | w_mant[0]);
  assign w_unused = ^{w_mant_r[MAN_W], w_sub[RW-1]};
`else
  assign w_inc    = 1'b0;
  assign w_unused = ^{w_mant_r[MAN_W], w_sub[RW-1], r_q[0], r_rem};
`endif
  assign w_mant_r = {1'b0, w_mant} + (MAN_W+2)'(w_inc);
  assign w_carry  = w_mant_r[MAN_W+1];
  assign w_ef     = r_e + EW'(w_carry);

  always_comb begin
    w_y   = {r_sign, {(W-1){1'b0}}};
    w_ovf = 1'b0;
    if (r_cls == CLS_INF) begin
      w_y   = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_ovf = 1'b1;
    end else if (r_cls == CLS_NORM) begin
      if (w_ef >= EMAX) begin
        w_y   = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        w_ovf = 1'b1;
      end else if (w_ef > EZERO) begin
        w_y = {r_sign, w_ef[EXP_W-1:0], w_mant_r[MAN_W-1:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_x1    <= '0;
      r_x2    <= '0;
      r_rem   <= '0;
      r_mb    <= '0;
      r_q     <= '0;
      r_e     <= '0;
      r_sign  <= 1'b0;
      r_cls   <= CLS_NORM;
      r_cnt   <= '0;
      r_y     <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bus.ready) begin
        // A new start always wins, including over a pending ROUND write.
        r_x1    <= bus.x1;
        r_x2    <= bus.x2;
        r_state <= PREP;
      end else begin
        case (r_state)
          PREP: begin
            r_rem   <= w_rem0;
            r_mb    <= w_mb;
            r_e     <= w_e0;
            r_sign  <= r_x1[W-1] ^ r_x2[W-1];
            r_cls   <= w_cls;
            r_q     <= '0;
            r_cnt   <= '0;
            r_state <= ITER;
          end
          ITER: begin
            r_rem <= {w_sub[RW-2:0], 1'b0};
            r_q   <= {r_q[QW-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(NITER - 1)) r_state <= ROUND;
          end
          ROUND: begin
            r_y     <= w_y;
            r_ovf   <= w_ovf;
            r_valid <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.y_reg   = r_y;
  assign bus.ovf_reg = r_ovf;
  assign bus.valid   = r_valid;
  assign bus.busy    = (r_state != IDLE);
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_fdiv_iter.sv
// Directed bench for fdiv_iter (fp32 parameters): vector table plus abort and reset sequences.
module tb_fdiv_iter;
  localparam int LAT = 27;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_pass;

  fdiv_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fdiv_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.ready = 1'b1;
    bus.x1    = a;
    bus.x2    = b;
    @(negedge clk);
    bus.ready = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit busy_ok, output bit width_ok,
                        output logic [31:0] y, output logic ovf);
    start_op(a, b);
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.valid && lat < 60) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    y   = bus.y_reg;
    ovf = bus.ovf_reg;
    @(negedge clk);
    width_ok = !bus.valid;
  endtask

  initial begin
    int          lat;
    bit          busy_ok;
    bit          width_ok;
    logic [31:0] y;
    logic        ovf;
    int          pulses;
    int          first;
    logic [31:0] y_at;

    n_checks = 0;
    n_pass   = 0;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};  // 6/2
`ifdef FDIV_RNE_EN
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0};  // 1/3
    vecs[2]  = '{32'h40000000, 32'h40400000, 32'h3F2AAAAB, 1'b0};  // 2/3
`else
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0};
    vecs[2]  = '{32'h40000000, 32'h40400000, 32'h3F2AAAAA, 1'b0};
`endif
    vecs[3]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1};  // -1/0
    vecs[4]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1};  // overflow
    vecs[5]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0};  // underflow
    vecs[6]  = '{32'h00000000, 32'h40A00000, 32'h00000000, 1'b0};  // 0/5
    vecs[7]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 1'b1};  // inf/2
    vecs[8]  = '{32'h40000000, 32'h7F800000, 32'h00000000, 1'b0};  // 2/inf
    vecs[9]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0};  // -6/2
    vecs[10] = '{32'h00000000, 32'h00000000, 32'h7F800000, 1'b1};  // 0/0
    vecs[11] = '{32'h3FC00000, 32'hBFC00000, 32'hBF800000, 1'b0};  // 1.5/-1.5

    rst       = 1'b1;
    bus.ready = 1'b0;
    bus.x1    = '0;
    bus.x2    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_y", bus.y_reg, 32'h0);
    check("reset_ovf", {31'b0, bus.ovf_reg}, 32'h0);
    check("reset_valid", {31'b0, bus.valid}, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_state", {30'b0, dbg_state}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].x1, vecs[i].x2, lat, busy_ok, width_ok, y, ovf);
      check($sformatf("v%0d_latency", i), lat, LAT);
      check($sformatf("v%0d_y", i), y, vecs[i].y);
      check($sformatf("v%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].ovf});
      check($sformatf("v%0d_busy", i), {31'b0, busy_ok}, 32'h1);
      check($sformatf("v%0d_pulse", i), {31'b0, width_ok}, 32'h1);
    end

    // Abort: a second start 10 cycles into 1/3 replaces it with 6/2.
    pulses = 0;
    start_op(32'h3F800000, 32'h40400000);
    for (int i = 0; i < 9; i++) begin
      if (bus.valid) pulses++;
      @(negedge clk);
    end
    bus.ready = 1'b1;
    bus.x1    = 32'h40C00000;
    bus.x2    = 32'h40000000;
    @(negedge clk);
    bus.ready = 1'b0;
    check("abort_valid_low", {31'b0, bus.valid}, 32'h0);
    lat   = 0;
    first = -1;
    y_at  = '0;
    for (int i = 0; i < 45; i++) begin
      if (bus.valid) begin
        pulses++;
        if (first < 0) begin
          first = lat;
          y_at  = bus.y_reg;
        end
      end
      @(negedge clk);
      lat++;
    end
    check("abort_pulses", pulses, 1);
    check("abort_latency", first, LAT);
    check("abort_y", y_at, 32'h40400000);

    // Reset 5 cycles into an operation.
    start_op(32'h40C00000, 32'h40000000);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_y", bus.y_reg, 32'h0);
    check("rst_state", {30'b0, dbg_state}, 32'h0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.valid) pulses++;
      @(negedge clk);
    end
    check("rst_no_valid", pulses, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fdiv_iter.md
Name: fdiv_iter

Overview:
- Parametrised iterative floating-point divider computing y = x1 / x2 with a start/valid handshake.
- Sits beside the FPU arithmetic units and is driven by the execute stage.
- Generalises the fixed fp32 multi-cycle divider: exponent and fraction widths are configurable, and the quotient is produced by a radix-2 restoring loop instead of table/Newton stages.
- Latency is fixed and operand-independent. An optional round-to-nearest-even mode is available, and in-flight operations can be aborted by reset or by a new start.

Parameters:
- EXP_W, 8: exponent field width.
- MAN_W, 23: stored fraction width. Total word width W = 1+EXP_W+MAN_W.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous active-high reset.
- ready, input, 1: start pulse; x1/x2 are sampled on the edge where ready=1.
- x1, input, W: dividend.
- x2, input, W: divisor.
- y_reg, output, W: quotient; holds its value until the next completion.
- ovf_reg, output, 1: overflow / divide-by-zero flag, qualified by valid.
- valid, output, 1: one-cycle completion pulse.
- busy, output, 1: high from the edge after ready is sampled until valid is asserted.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: y_reg=0, ovf_reg=0, valid=0, busy=0, state=IDLE. rst has priority over ready.
- States:
  - IDLE: wait for ready.
  - PREP: 1 cycle. Unpack operands, classify special cases, align mantissas.
  - ITER: MAN_W+2 cycles, one quotient bit per cycle.
  - ROUND: 1 cycle. Round, pack, write y_reg/ovf_reg, pulse valid. Then return to IDLE.
- Latency: valid is high in the cycle after the (MAN_W+4)th edge following the edge that sampled ready, i.e. 27 cycles for default parameters. Special cases take the same latency.
- ready in any state, including busy, aborts the current operation, re-samples the operands and restarts in PREP. The aborted operation produces no valid pulse. valid is 0 in the cycle after ready is sampled.
- Unpack:
  - Denormal inputs (exp=0) are flushed to zero.
  - ma = {1,f1}, mb = {1,f2}, each MAN_W+1 bits.
  - sign = s1^s2.
  - If ma < mb: ma <<= 1 and adj = 1.
  - e = e1 - e2 + BIAS - adj, computed in EXP_W+2-bit signed arithmetic, with BIAS = 2^(EXP_W-1)-1.
- Iteration (restoring): per cycle, q_bit = (rem >= mb); if set, rem -= mb; then rem <<= 1. rem starts at ma.
  - Produces MAN_W+1 quotient bits plus 1 guard bit.
  - sticky = (final rem != 0).
- Rounding: see Optional Feature. A mantissa carry-out (1.111..1 rounds up to 2.0) yields mantissa 1.0 and e+1.
- Result classification, in priority order:
  1. x2 zero, or x1 exp all-ones: y = {sign, all-ones exp, 0 frac}, ovf=1. This includes 0/0.
  2. x1 zero: y = {sign, 0}, ovf=0.
  3. x2 exp all-ones: y = {sign, 0}, ovf=0.
  4. e (after rounding carry) >= 2^EXP_W-1: y = signed infinity, ovf=1.
  5. e <= 0: y = signed zero (flush), ovf=0.
  6. Otherwise: normal packing, ovf=0.
- NaN payloads are not propagated; exp all-ones is treated as infinity.
- Reset mid-operation: the next cycle is IDLE, there is no valid pulse, and y_reg is cleared to 0.

Optional Feature:
- Macro: FDIV_RNE_EN.
- Defined: round-to-nearest-even. Increment when guard & (sticky | lsb).
- Undefined: truncate. Guard and sticky are ignored.
- Iteration count and latency are identical in both modes.

Test Plan:
- 6.0/2.0: x1=0x40C00000, x2=0x40000000, ready 1 cycle -> y_reg=0x40400000, ovf_reg=0; valid high exactly 27 cycles later, for 1 cycle; busy high throughout.
- 1.0/3.0: x1=0x3F800000, x2=0x40400000 -> y_reg=0x3EAAAAAB with FDIV_RNE_EN; 0x3EAAAAAA without.
- Divide by zero: x1=0xBF800000, x2=0x00000000 -> y_reg=0xFF800000, ovf_reg=1, latency still 27.
- Overflow / underflow:
  - 0x7F000000 / 0x3E800000 -> y_reg=0x7F800000, ovf_reg=1.
  - 0x00800000 / 0x40000000 -> y_reg=0x00000000, ovf_reg=0.
- Abort and reset:
  - Start 1.0/3.0, then re-assert ready 10 cycles later with 6.0/2.0 -> exactly one valid pulse, 27 cycles after the second ready, y_reg=0x40400000.
  - Separately, rst 5 cycles into an operation -> no valid pulse, busy=0, y_reg=0.
